// File: rtl/reg_snapshot_streamer_if.sv
// reg_snapshot_streamer_if: byte-stream valid/ready bus carrying snapshot frames
interface reg_snapshot_streamer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/reg_snapshot_streamer.sv
// reg_snapshot_streamer: captures a register file atomically and streams it as a header/data/checksum byte frame
module reg_snapshot_streamer #(
   parameter int         NUM_REGS = 26,
   parameter int         DATA_W   = 32,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
   reg_snapshot_streamer_if.master    out,
   output logic                       busy,
   output logic                       done
);
   localparam int BYTES = DATA_W / 8;
   localparam int RW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
   localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
   typedef enum logic [1:0] {IDLE, HEADER, DATA, CSUM} state_t;
   state_t            state, state_nx;
   logic [DATA_W-1:0] shadow [NUM_REGS];
   logic [DATA_W-1:0] word;
   logic [RW-1:0]     ridx, ridx_nx;
   logic [BW-1:0]     bidx, bidx_nx;
   logic [7:0]        csum, csum_nx, data_byte;
   logic              acc;
   assign acc = out.out_valid && out.out_ready;
   // Output byte is looked up from the next indices so the registered output already shows the upcoming byte
   assign word = shadow[ridx_nx];
   assign data_byte = word[8*(BYTES-1-int'(bidx_nx)) +: 8];
   // State register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // Next state and index/checksum advance; only an accepted byte moves the frame forward
   always_comb begin
      state_nx = state;
      ridx_nx = ridx;
      bidx_nx = bidx;
      csum_nx = csum;
      case (state)
         IDLE: if (start) begin
            state_nx = HEADER;
            ridx_nx = '0;
            bidx_nx = '0;
            csum_nx = '0;
         end
         HEADER: if (acc) state_nx = DATA;
         DATA: if (acc) begin
            csum_nx = csum ^ out.out_data;
            bidx_nx = (bidx == BW'(BYTES-1)) ? '0 : bidx + 1'b1;
            if (bidx == BW'(BYTES-1)) begin
               if (ridx == RW'(NUM_REGS-1)) state_nx = CSUM;
               else ridx_nx = ridx + 1'b1;
            end
         end
         CSUM: if (acc) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // Snapshot capture: only on the start edge in IDLE, so later regs_flat changes never reach the frame
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end else if (state == IDLE && start) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= regs_flat[i*DATA_W +: DATA_W];
      end
   // Counters and registered outputs, all derived from the next state so outputs hold steady while stalled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ridx <= '0;
         bidx <= '0;
         csum <= '0;
         out.out_data <= '0;
         out.out_valid <= 1'b0;
         out.out_last <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         ridx <= ridx_nx;
         bidx <= bidx_nx;
         csum <= csum_nx;
         out.out_data <= state_nx == HEADER ? HDR_BYTE : state_nx == DATA ? data_byte : state_nx == CSUM ? csum_nx : 8'h00;
         out.out_valid <= state_nx != IDLE;
         out.out_last <= state_nx == CSUM;
         busy <= state_nx != IDLE;
         done <= state == CSUM && state_nx == IDLE;
      end
endmodule
